monster_walker: RTL

- Per-monster motion and life controller: random walk over the tile map, with hit-point tracking.
- Produces monster_r / monster_c / monster_alive, which the player module consumes for contact damage.
- Produces monster_v / monster_h pixel coordinates for the monster sprite renderer.
- Queries the map block through the same dest_r / dest_c / dest_type interface the player uses; the top level instantiates one per monster.

---
 rtl/game_defs_pkg.sv | 48 ++++
 rtl/monster_walker_lfsr16.sv | 28 ++
 rtl/monster_walker.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/game_defs_pkg.sv
// Shared game encodings: map tile codes, motion codes, sprite geometry and
// the monster controller state encoding, plus small tile/pixel helpers.
package game_defs;

  localparam logic [2:0] MAP_WALL   = 3'd0;
  localparam logic [2:0] MAP_ROAD0  = 3'd1;
  localparam logic [2:0] MAP_ROAD1  = 3'd2;
  localparam logic [2:0] MAP_STAIRS = 3'd3;

  localparam logic [2:0] MOVE_STOP  = 3'd0;
  localparam logic [2:0] MOVE_DOWN  = 3'd1;
  localparam logic [2:0] MOVE_UP    = 3'd2;
  localparam logic [2:0] MOVE_LEFT  = 3'd3;
  localparam logic [2:0] MOVE_RIGHT = 3'd4;

  localparam int SPRITE_LEN     = 32;
  localparam int SPRITE_LOG_LEN = 5;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_QUERY = 2'd1,
    MON_WALK  = 2'd2,
    MON_DEAD  = 2'd3
  } mon_state_e;

  function automatic logic [2:0] pick_dir(input logic [1:0] sel);
    logic [2:0] d;
    d = MOVE_DOWN;
    case (sel)
      2'd1:    d = MOVE_UP;
      2'd2:    d = MOVE_LEFT;
      2'd3:    d = MOVE_RIGHT;
      default: d = MOVE_DOWN;
    endcase
    return d;
  endfunction

  function automatic logic tile_walkable(input logic [2:0] t);
    return (t == MAP_ROAD0) || (t == MAP_ROAD1) || (t == MAP_STAIRS);
  endfunction

  function automatic logic [9:0] tile_to_px(input logic [9:0] t);
    return {t[9-SPRITE_LOG_LEN:0], {SPRITE_LOG_LEN{1'b0}}};
  endfunction

endpackage

// File: rtl/monster_walker_lfsr16.sv
// 16-bit right-shifting Galois LFSR; free-runs every cycle outside reset.
module lfsr16
  import game_defs::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  // NOTE: every combinational output gets a default before any branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = {1'b0, state_q[15:1]};
    if (state_q[0]) state_d = state_d ^ LFSR_MASK;
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/monster_walker.sv
// Per-monster random-walk controller: idles, probes the map for a walkable
// neighbour, glides one tile over STEP_DELAY*32 cycles, dies after HP_FULL hits.
module monster_walker
  import game_defs::*;
#(
  parameter int unsigned START_R     = 5,
  parameter int unsigned START_C     = 5,
  parameter int unsigned HP_FULL     = 3,
  parameter int unsigned IDLE_CYCLES = 4096,
  parameter int unsigned STEP_DELAY  = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [2:0]  MAP_ID      = 3'd0
) (
  input  logic       clk_13,
  input  logic       rst,
  input  logic [2:0] map_idx,
  input  logic [2:0] dest_type,
  output logic [9:0] dest_r,
  output logic [9:0] dest_c,
  input  logic       hit,
  output logic [9:0] monster_r,
  output logic [9:0] monster_c,
  output logic       monster_alive,
  output logic [2:0] monster_dir,
  output logic [9:0] monster_v,
  output logic [9:0] monster_h
);

  localparam int unsigned WALK_CYCLES = STEP_DELAY * SPRITE_LEN;
  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WALK_W = $clog2(WALK_CYCLES);

  localparam logic [IDLE_W-1:0] IDLE_RELOAD = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE    = IDLE_W'(1);
  localparam logic [WALK_W-1:0] WALK_RELOAD = WALK_W'(WALK_CYCLES - 1);
  localparam logic [WALK_W-1:0] WALK_ONE    = WALK_W'(1);
  localparam logic [WALK_W-1:0] STEP_MASK   = WALK_W'(STEP_DELAY - 1);
  localparam logic [9:0]        R_RST       = 10'(START_R);
  localparam logic [9:0]        C_RST       = 10'(START_C);
  localparam logic [3:0]        HP_RST      = 4'(HP_FULL);

  mon_state_e        state_q, state_d;
  logic [9:0]        r_q, r_d, c_q, c_d, v_q, v_d, h_q, h_d;
  logic [3:0]        hp_q, hp_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WALK_W-1:0] walk_cnt_q, walk_cnt_d;
  logic [2:0]        dir_q, dir_d;

  logic [15:0] lfsr_state;
  logic [13:0] lfsr_unused;
  logic [9:0]  dr, dc;
  logic        on_map, hit_ok, blocked;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk_13),
    .rst     (rst),
    .state_o (lfsr_state)
  );

  assign lfsr_unused = lfsr_state[15:2];

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    v_d        = v_q;
    h_d        = h_q;
    idle_cnt_d = idle_cnt_q;
    walk_cnt_d = walk_cnt_q;
    dir_d      = dir_q;
    dest_r     = r_q;
    dest_c     = c_q;

    // Unit offsets in two's complement; the pixel step reuses the tile offset.
    dr = '0;
    dc = '0;
    case (dir_q)
      MOVE_DOWN:  dr = 10'd1;
      MOVE_UP:    dr = '1;
      MOVE_LEFT:  dc = '1;
      MOVE_RIGHT: dc = 10'd1;
      default:    ;
    endcase

    on_map  = (map_idx == MAP_ID);
    hit_ok  = hit && on_map && (hp_q != '0);
    hp_d    = hit_ok ? hp_q - 4'd1 : hp_q;
    blocked = ((dir_q == MOVE_UP) && (r_q == '0)) || ((dir_q == MOVE_LEFT) && (c_q == '0));

    unique case (state_q)
      MON_IDLE: begin
        if (on_map) begin
          if (idle_cnt_q == '0) begin
            dir_d   = pick_dir(lfsr_state[1:0]);
            state_d = MON_QUERY;
          end else begin
            idle_cnt_d = idle_cnt_q - IDLE_ONE;
          end
        end
      end
      MON_QUERY: begin
        dest_r = r_q + dr;
        dest_c = c_q + dc;
        if (tile_walkable(dest_type) && !blocked) begin
          state_d    = MON_WALK;
          walk_cnt_d = WALK_RELOAD;
        end else begin
          state_d    = MON_IDLE;
          idle_cnt_d = IDLE_RELOAD;
        end
      end
      MON_WALK: begin
        if (walk_cnt_q == '0) begin
          r_d        = r_q + dr;
          c_d        = c_q + dc;
          v_d        = tile_to_px(r_q + dr);
          h_d        = tile_to_px(c_q + dc);
          state_d    = MON_IDLE;
          idle_cnt_d = IDLE_RELOAD;
        end else begin
          walk_cnt_d = walk_cnt_q - WALK_ONE;
          if ((walk_cnt_q & STEP_MASK) == '0) begin
            v_d = v_q + dr;
            h_d = h_q + dc;
          end
        end
      end
      MON_DEAD: ;
    endcase

    // The killing hit overrides any commit or step issued this cycle.
    if (hit_ok && (hp_q == 4'd1)) begin
      state_d = MON_DEAD;
      r_d     = r_q;
      c_d     = c_q;
      v_d     = tile_to_px(r_q);
      h_d     = tile_to_px(c_q);
    end
  end

  always_ff @(posedge clk_13) begin
    if (rst) begin
      state_q    <= MON_IDLE;
      r_q        <= R_RST;
      c_q        <= C_RST;
      v_q        <= tile_to_px(R_RST);
      h_q        <= tile_to_px(C_RST);
      hp_q       <= HP_RST;
      idle_cnt_q <= IDLE_RELOAD;
      walk_cnt_q <= '0;
      dir_q      <= MOVE_STOP;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      v_q        <= v_d;
      h_q        <= h_d;
      hp_q       <= hp_d;
      idle_cnt_q <= idle_cnt_d;
      walk_cnt_q <= walk_cnt_d;
      dir_q      <= dir_d;
    end
  end

  assign monster_r     = r_q;
  assign monster_c     = c_q;
  assign monster_v     = v_q;
  assign monster_h     = h_q;
  assign monster_alive = (hp_q != '0);
  assign monster_dir   = (state_q == MON_WALK) ? dir_q : MOVE_STOP;

endmodule
